// File: rtl/sha_sigma_sequencer_if.sv
// Request/response handshakes plus the ALU drive/result bus of the SHA-256 sigma sequencer.
// slave = sequencer side, master = control/ALU environment side.
interface sha_sigma_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [1:0]  in_func;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shiftamt;
  logic [31:0] alu_result;

  modport slave (
    input  in_valid, in_word, in_func, out_ready, alu_result,
    output in_ready, out_valid, out_result,
    output alu_operandA, alu_operandB, alu_opcode, alu_shiftamt
  );

  modport master (
    output in_valid, in_word, in_func, out_ready, alu_result,
    input  in_ready, out_valid, out_result,
    input  alu_operandA, alu_operandB, alu_opcode, alu_shiftamt
  );
endinterface

// File: rtl/sha_sigma_sequencer.sv
// Sequences ROTR/SRL/XOR micro-ops on the shared ALU to compute SHA-256 sigma functions.
// Optional SHA_SIGMA_CHECK_EN adds a sticky check_err comparing the X2 ALU result to a reference.
module sha_sigma_sequencer #(
  parameter logic [4:0] OPC_ROTR = 5'b01001,
  parameter logic [4:0] OPC_SRL  = 5'b01011,
  parameter logic [4:0] OPC_XOR  = 5'b01000,
  parameter logic [4:0] OPC_IDLE = 5'b00000
) (
  input  logic                 clock,
  input  logic                 reset,
  sha_sigma_sequencer_if.slave bus
`ifdef SHA_SIGMA_CHECK_EN
  ,
  output logic                 check_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_R1, S_R2, S_X1, S_R3, S_X2, S_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opc;
    logic [4:0]  shamt;
  } alu_drv_t;

  state_t      state;
  logic [31:0] x, acc, tmp, out_result_q;
  logic [1:0]  func;
  logic        in_ready_q, out_valid_q;
  logic [4:0]  k1, k2, k3;
  alu_drv_t    drv;

  always_comb begin
    k1 = 5'd2; k2 = 5'd13; k3 = 5'd22;
    case (func)
      2'd0: begin k1 = 5'd2;  k2 = 5'd13; k3 = 5'd22; end
      2'd1: begin k1 = 5'd6;  k2 = 5'd11; k3 = 5'd25; end
      2'd2: begin k1 = 5'd7;  k2 = 5'd18; k3 = 5'd3;  end
      2'd3: begin k1 = 5'd17; k2 = 5'd19; k3 = 5'd10; end
      default: ;
    endcase
  end

  // ALU drive decodes registered state only, so it never follows in_valid/out_ready.
  always_comb begin
    drv = '0;
    drv.opc = OPC_IDLE;
    case (state)
      S_R1: begin drv.a = x;   drv.opc = OPC_ROTR; drv.shamt = k1; end
      S_R2: begin drv.a = x;   drv.opc = OPC_ROTR; drv.shamt = k2; end
      S_X1: begin drv.a = acc; drv.b = tmp; drv.opc = OPC_XOR; end
      S_R3: begin
        drv.a     = x;
        drv.opc   = func[1] ? OPC_SRL : OPC_ROTR;
        drv.shamt = k3;
      end
      S_X2: begin drv.a = acc; drv.b = tmp; drv.opc = OPC_XOR; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      x            <= '0;
      acc          <= '0;
      tmp          <= '0;
      func         <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid && in_ready_q) begin
          x          <= bus.in_word;
          func       <= bus.in_func;
          in_ready_q <= 1'b0;
          state      <= S_R1;
        end
        S_R1: begin acc <= bus.alu_result; state <= S_R2; end
        S_R2: begin tmp <= bus.alu_result; state <= S_X1; end
        S_X1: begin acc <= bus.alu_result; state <= S_R3; end
        S_R3: begin tmp <= bus.alu_result; state <= S_X2; end
        S_X2: begin
          out_result_q <= bus.alu_result;
          out_valid_q  <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.alu_operandA = drv.a;
  assign bus.alu_operandB = drv.b;
  assign bus.alu_opcode   = drv.opc;
  assign bus.alu_shiftamt = drv.shamt;

`ifdef SHA_SIGMA_CHECK_EN
  function automatic logic [31:0] rotr(input logic [31:0] v, input logic [4:0] s);
    return (v >> s) | (v << (6'd32 - {1'b0, s}));
  endfunction

  function automatic logic [31:0] sigma_ref(input logic [31:0] v, input logic [1:0] f);
    case (f)
      2'd0:    return rotr(v, 5'd2)  ^ rotr(v, 5'd13) ^ rotr(v, 5'd22);
      2'd1:    return rotr(v, 5'd6)  ^ rotr(v, 5'd11) ^ rotr(v, 5'd25);
      2'd2:    return rotr(v, 5'd7)  ^ rotr(v, 5'd18) ^ (v >> 3);
      default: return rotr(v, 5'd17) ^ rotr(v, 5'd19) ^ (v >> 10);
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      check_err <= 1'b0;
    else if (state == S_X2 && bus.alu_result != sigma_ref(x, func))
      check_err <= 1'b1;
  end
`endif

endmodule
